// File: rtl/gps_ce_pkg.sv
// Shared types and clamp helpers for the GPS clock-enable generator.
package gps_ce_pkg;

    localparam int unsigned CFG_CH_W  = 3;
    localparam int unsigned CFG_DIV_W = 8;

    typedef struct packed {
        logic [CFG_DIV_W-1:0] div;
        logic [CFG_DIV_W-1:0] phase;
    } ce_cfg_t;

    function automatic logic [CFG_DIV_W-1:0] div_eff(input logic [CFG_DIV_W-1:0] div);
        return (div == '0) ? CFG_DIV_W'(1) : div;
    endfunction

    function automatic logic [CFG_DIV_W-1:0] phase_eff(input logic [CFG_DIV_W-1:0] phase,
                                                       input logic [CFG_DIV_W-1:0] div_e);
        return (phase > div_e - CFG_DIV_W'(1)) ? div_e - CFG_DIV_W'(1) : phase;
    endfunction

endpackage

// File: rtl/gps_ce_gen_if.sv
// Configuration bus of the clock-enable generator: write strobe, target, values, pending flags.
interface gps_ce_gen_if
    import gps_ce_pkg::*;
#(
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned DIV_W  = 8
) ();

    logic                cfg_wr;
    logic [CFG_CH_W-1:0] cfg_ch;
    logic [DIV_W-1:0]    cfg_div;
    logic [DIV_W-1:0]    cfg_phase;
    logic [NUM_CH-1:0]   cfg_pending;

    modport master (
        output cfg_wr, cfg_ch, cfg_div, cfg_phase,
        input  cfg_pending
    );

    modport slave (
        input  cfg_wr, cfg_ch, cfg_div, cfg_phase,
        output cfg_pending
    );

endinterface

// File: rtl/gps_ce_chan.sv
// One divide channel: counter, shadow/active config, registered strobe and square wave.
module gps_ce_chan
    import gps_ce_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 run,
    input  logic                 resync,
    input  logic                 wr,
    input  ce_cfg_t              wr_cfg,
    input  logic [CFG_DIV_W-1:0] def_div,
    output logic                 pending,
    output logic                 ce,
    output logic                 sq,
    output logic                 tc
);

    logic [CFG_DIV_W-1:0] cnt_q, cnt_d, div_e, new_div_e;
    ce_cfg_t              act_q, act_d, sh_q, sh_d;
    logic                 pend_q, pend_d, ce_q, ce_d, sq_q, sq_d;
    logic                 xfer;

    always_comb begin
        div_e  = div_eff(act_q.div);
        // >= so a count left above a freshly shortened divisor still wraps
        tc     = (cnt_q >= div_e - CFG_DIV_W'(1));
        sh_d   = wr ? wr_cfg : sh_q;
        pend_d = pend_q | wr;
        act_d  = act_q;
        xfer   = resync | ~run | tc;
        if (xfer && pend_d) begin
            act_d  = sh_d;
            pend_d = 1'b0;
        end
        new_div_e = div_eff(act_d.div);
        cnt_d     = cnt_q;
        ce_d      = 1'b0;
        sq_d      = sq_q;
        if (resync) begin
            cnt_d = phase_eff(act_d.phase, new_div_e);
            sq_d  = 1'b0;
        end else if (run) begin
            if (tc) begin
                cnt_d = '0;
                ce_d  = 1'b1;
                sq_d  = ~sq_q;
            end else begin
                cnt_d = cnt_q + CFG_DIV_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            act_q  <= '{div: def_div, phase: '0};
            sh_q   <= '0;
            pend_q <= 1'b0;
            ce_q   <= 1'b0;
            sq_q   <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            act_q  <= act_d;
            sh_q   <= sh_d;
            pend_q <= pend_d;
            ce_q   <= ce_d;
            sq_q   <= sq_d;
        end
    end

    assign pending = pend_q;
    assign ce      = ce_q;
    assign sq      = sq_q;

endmodule

// File: rtl/gps_ce_gen.sv
// Multi-channel programmable clock-enable generator with coherent resync and common epoch.
module gps_ce_gen
    import gps_ce_pkg::*;
#(
    parameter int unsigned              NUM_CH  = 2,
    parameter int unsigned              DIV_W   = CFG_DIV_W,
    parameter logic [NUM_CH*DIV_W-1:0]  DEF_DIV = {8'd10, 8'd1},
    parameter int unsigned              EPOCH_W = 16
) (
    input  logic               sys_clk_50,
    input  logic               sync_rst_in,
    input  logic               run,
    input  logic               resync,
    gps_ce_gen_if.slave        cfg,
    output logic [NUM_CH-1:0]  ce_out,
    output logic [NUM_CH-1:0]  sq_out,
    output logic               epoch,
    output logic [EPOCH_W-1:0] epoch_cnt
);

    logic [NUM_CH-1:0]  ch_wr, tc, pending;
    ce_cfg_t            wr_cfg;
    logic               epoch_q, epoch_d;
    logic [EPOCH_W-1:0] epoch_cnt_q;

    assign wr_cfg = '{div: CFG_DIV_W'(cfg.cfg_div), phase: CFG_DIV_W'(cfg.cfg_phase)};

    // Writes to channel numbers beyond NUM_CH match no decoder and are dropped
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign ch_wr[i] = cfg.cfg_wr && (cfg.cfg_ch == CFG_CH_W'(i));

        gps_ce_chan u_chan (
            .clk     (sys_clk_50),
            .rst     (sync_rst_in),
            .run     (run),
            .resync  (resync),
            .wr      (ch_wr[i]),
            .wr_cfg  (wr_cfg),
            .def_div (CFG_DIV_W'(DEF_DIV[i*DIV_W +: DIV_W])),
            .pending (pending[i]),
            .ce      (ce_out[i]),
            .sq      (sq_out[i]),
            .tc      (tc[i])
        );
    end

    assign cfg.cfg_pending = pending;

    always_comb begin
        epoch_d = run & ~resync & (&tc);
    end

    always_ff @(posedge sys_clk_50) begin
        if (sync_rst_in) begin
            epoch_q     <= 1'b0;
            epoch_cnt_q <= '0;
        end else begin
            epoch_q <= epoch_d;
            if (epoch_d) begin
                epoch_cnt_q <= epoch_cnt_q + EPOCH_W'(1);
            end
        end
    end

    assign epoch     = epoch_q;
    assign epoch_cnt = epoch_cnt_q;

endmodule

// File: tb/tb_gps_ce_gen.sv
// Directed bench for gps_ce_gen: defaults, reconfiguration, resync, clamps, stall, reset, wrap.
module tb_gps_ce_gen;
    import gps_ce_pkg::*;

    logic        clk = 1'b0;
    logic        rst, run, resync, cfg_wr;
    logic [2:0]  cfg_ch;
    logic [7:0]  cfg_div, cfg_phase;
    logic [1:0]  ce_out, sq_out, ce_out2, sq_out2;
    logic        epoch, epoch2;
    logic [15:0] epoch_cnt;
    logic [1:0]  epoch_cnt2;
    int          n_tests = 0;
    int          n_fail  = 0;

    gps_ce_gen_if #(.NUM_CH(2), .DIV_W(8)) if1 ();
    gps_ce_gen_if #(.NUM_CH(2), .DIV_W(8)) if2 ();

    assign if1.cfg_wr    = cfg_wr;
    assign if1.cfg_ch    = cfg_ch;
    assign if1.cfg_div   = cfg_div;
    assign if1.cfg_phase = cfg_phase;
    assign if2.cfg_wr    = cfg_wr;
    assign if2.cfg_ch    = cfg_ch;
    assign if2.cfg_div   = cfg_div;
    assign if2.cfg_phase = cfg_phase;

    gps_ce_gen #(.NUM_CH(2), .DIV_W(8), .DEF_DIV({8'd10, 8'd1}), .EPOCH_W(16)) dut (
        .sys_clk_50  (clk),
        .sync_rst_in (rst),
        .run         (run),
        .resync      (resync),
        .cfg         (if1),
        .ce_out      (ce_out),
        .sq_out      (sq_out),
        .epoch       (epoch),
        .epoch_cnt   (epoch_cnt)
    );

    // Narrow epoch counter to observe the wrap
    gps_ce_gen #(.NUM_CH(2), .DIV_W(8), .DEF_DIV({8'd10, 8'd1}), .EPOCH_W(2)) dut2 (
        .sys_clk_50  (clk),
        .sync_rst_in (rst),
        .run         (run),
        .resync      (resync),
        .cfg         (if2),
        .ce_out      (ce_out2),
        .sq_out      (sq_out2),
        .epoch       (epoch2),
        .epoch_cnt   (epoch_cnt2)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; run = 1'b0; resync = 1'b0;
        cfg_wr = 1'b0; cfg_ch = 3'd0; cfg_div = 8'd0; cfg_phase = 8'd0;
        @(negedge clk);
        check("rst_ce",      32'(ce_out), 32'd0);
        check("rst_sq",      32'(sq_out), 32'd0);
        check("rst_epoch",   32'(epoch), 32'd0);
        check("rst_ecnt",    32'(epoch_cnt), 32'd0);
        check("rst_pend",    32'(if1.cfg_pending), 32'd0);
        check("rst_ce2",     32'(ce_out2), 32'd0);
        check("rst_sq2",     32'(sq_out2), 32'd0);
        check("rst_epoch2",  32'(epoch2), 32'd0);
        check("rst_pend2",   32'(if2.cfg_pending), 32'd0);

        // Defaults: div 1 and div 10
        rst = 1'b0; run = 1'b1;
        for (int e = 1; e <= 40; e++) begin
            @(negedge clk);
            check("def_ce0",   32'(ce_out[0]), 32'd1);
            check("def_ce1",   32'(ce_out[1]), 32'(e % 10 == 0));
            check("def_epoch", 32'(epoch), 32'(e % 10 == 0));
            check("def_sq0",   32'(sq_out[0]), 32'(e % 2));
            if (e % 10 == 0) check("def_sq1", 32'(sq_out[1]), 32'((e / 10) % 2));
        end
        check("def_ecnt", 32'(epoch_cnt), 32'd4);

        // div=5 written at cnt=3; old 10-cycle period must complete
        for (int e = 41; e <= 43; e++) begin
            @(negedge clk);
            check("b_ce1_pre", 32'(ce_out[1]), 32'd0);
        end
        cfg_wr = 1'b1; cfg_ch = 3'd1; cfg_div = 8'd5; cfg_phase = 8'd0;
        @(negedge clk);
        cfg_wr = 1'b0;
        check("b_pend", 32'(if1.cfg_pending), 32'd2);
        for (int e = 45; e <= 60; e++) begin
            @(negedge clk);
            check("b_pend1", 32'(if1.cfg_pending[1]), 32'(e < 50));
            check("b_ce1",   32'(ce_out[1]), 32'(e == 50 || e == 55 || e == 60));
            if (e == 50) begin
                check("b_ecnt5",   32'(epoch_cnt), 32'd5);
                check("wrap_ecnt", 32'(epoch_cnt2), 32'd1);
            end
        end
        check("b_sq1",  32'(sq_out[1]), 32'd1);
        check("b_ecnt", 32'(epoch_cnt), 32'd7);

        // phase 7 with div 10, then resync
        cfg_wr = 1'b1; cfg_ch = 3'd1; cfg_div = 8'd10; cfg_phase = 8'd7;
        @(negedge clk);
        check("c_pend", 32'(if1.cfg_pending), 32'd2);
        cfg_wr = 1'b0; resync = 1'b1;
        @(negedge clk);
        resync = 1'b0;
        check("c_rs_ce",    32'(ce_out), 32'd0);
        check("c_rs_sq",    32'(sq_out), 32'd0);
        check("c_rs_pend",  32'(if1.cfg_pending), 32'd0);
        check("c_rs_epoch", 32'(epoch), 32'd0);
        for (int e = 63; e <= 75; e++) begin
            @(negedge clk);
            check("c_ce1", 32'(ce_out[1]), 32'(e == 65 || e == 75));
        end
        check("c_ecnt", 32'(epoch_cnt), 32'd9);
        check("c_sq1",  32'(sq_out[1]), 32'd0);

        // div=0 acts as div 1 (write together with resync applies at once)
        cfg_wr = 1'b1; cfg_ch = 3'd1; cfg_div = 8'd0; cfg_phase = 8'd0; resync = 1'b1;
        @(negedge clk);
        cfg_wr = 1'b0; resync = 1'b0;
        check("d0_ce",   32'(ce_out), 32'd0);
        check("d0_pend", 32'(if1.cfg_pending), 32'd0);
        for (int e = 77; e <= 79; e++) begin
            @(negedge clk);
            check("d0_ce_run", 32'(ce_out), 32'd3);
            check("d0_epoch",  32'(epoch), 32'd1);
        end

        // phase 200 with div 5 clamps to 4
        cfg_wr = 1'b1; cfg_ch = 3'd1; cfg_div = 8'd5; cfg_phase = 8'd200; resync = 1'b1;
        @(negedge clk);
        cfg_wr = 1'b0; resync = 1'b0;
        check("ph_rs_ce", 32'(ce_out), 32'd0);
        for (int e = 81; e <= 86; e++) begin
            @(negedge clk);
            check("ph_ce1", 32'(ce_out[1]), 32'(e == 81 || e == 86));
        end

        // Write to nonexistent channel 5
        cfg_wr = 1'b1; cfg_ch = 3'd5; cfg_div = 8'd2; cfg_phase = 8'd0;
        @(negedge clk);
        cfg_wr = 1'b0;
        check("bad_ch_pend", 32'(if1.cfg_pending), 32'd0);
        for (int e = 88; e <= 91; e++) begin
            @(negedge clk);
            check("bad_ch_ce1", 32'(ce_out[1]), 32'(e == 91));
        end

        // run low for 6 cycles at ch1 cnt=2
        for (int e = 92; e <= 93; e++) begin
            @(negedge clk);
            check("st_pre_ce1", 32'(ce_out[1]), 32'd0);
        end
        run = 1'b0;
        for (int e = 94; e <= 99; e++) begin
            @(negedge clk);
            check("st_ce",    32'(ce_out), 32'd0);
            check("st_epoch", 32'(epoch), 32'd0);
            check("st_sq",    32'(sq_out), 32'd3);
        end
        run = 1'b1;
        for (int e = 100; e <= 102; e++) begin
            @(negedge clk);
            check("st_ce1", 32'(ce_out[1]), 32'(e == 102));
        end
        check("st_ecnt", 32'(epoch_cnt), 32'd16);

        // Reset wins over concurrent write and resync
        rst = 1'b1; cfg_wr = 1'b1; cfg_ch = 3'd1; cfg_div = 8'd3; cfg_phase = 8'd1; resync = 1'b1;
        @(negedge clk);
        check("r_ce",    32'(ce_out), 32'd0);
        check("r_sq",    32'(sq_out), 32'd0);
        check("r_epoch", 32'(epoch), 32'd0);
        check("r_ecnt",  32'(epoch_cnt), 32'd0);
        check("r_ecnt2", 32'(epoch_cnt2), 32'd0);
        check("r_pend",  32'(if1.cfg_pending), 32'd0);
        rst = 1'b0; cfg_wr = 1'b0; resync = 1'b0;
        for (int e = 104; e <= 113; e++) begin
            @(negedge clk);
            check("r_ce0", 32'(ce_out[0]), 32'd1);
            check("r_ce1", 32'(ce_out[1]), 32'(e == 113));
        end
        check("r_ecnt_after",  32'(epoch_cnt), 32'd1);
        check("r_ecnt2_after", 32'(epoch_cnt2), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/gps_ce_gen.md
Name: gps_ce_gen

Overview:
- Parametrised multi-channel clock-enable generator for the GPS subsystem.
- Replaces fixed divide-by-5/10 slow-clock logic with NUM_CH independently programmable divide channels on one clock.
- Each channel provides a one-cycle enable strobe, a square-wave output and a programmable phase.
- Coherent resync and a common-epoch pulse keep P-code (10.23 MHz) and C/A (1.023 MHz) timing aligned.

Parameters:
- NUM_CH, 2, number of divide channels (1..8).
- DIV_W, 8, width of divisor and phase fields.
- DEF_DIV, {8'd10, 8'd1}, packed reset divisors; channel i uses bits [i*DIV_W +: DIV_W].
- EPOCH_W, 16, width of the epoch counter.

Ports:
- sys_clk_50, in, 1, sole clock.
- sync_rst_in, in, 1, synchronous active-high reset.
- run, in, 1, global count enable.
- resync, in, 1, single-cycle pulse that reloads all channel counters with their phase.
- cfg_wr, in, 1, configuration write strobe.
- cfg_ch, in, 3, target channel of the write.
- cfg_div, in, DIV_W, divisor; 0 is treated as 1.
- cfg_phase, in, DIV_W, start count loaded on resync.
- cfg_pending, out, NUM_CH, shadow configuration not yet applied.
- ce_out, out, NUM_CH, one-cycle enable strobes.
- sq_out, out, NUM_CH, toggles on each strobe (50% duty for even divisor multiples).
- epoch, out, 1, one-cycle pulse when all channels strobe in the same cycle.
- epoch_cnt, out, EPOCH_W, count of epoch pulses; wraps.

Behaviour:
- Reset (sync_rst_in high at a clock edge):
  - cnt = 0, div_act = DEF_DIV, phase_act = 0, shadow cleared, cfg_pending = 0.
  - ce_out = 0, sq_out = 0, epoch = 0, epoch_cnt = 0.
  - Reset overrides every other input in that cycle.
- Effective values:
  - div_eff = max(div_act, 1).
  - phase_eff = min(phase_act, div_eff-1).
- Counting, per channel, each cycle with run=1 and resync=0:
  - If cnt == div_eff-1: cnt <= 0, ce_out[i] <= 1, sq_out[i] toggles.
  - Otherwise: cnt <= cnt+1, ce_out[i] <= 0.
  - All outputs are registered. The strobe appears the cycle after the terminal count, so the period is exactly div_eff cycles; div_eff=1 gives ce_out held high continuously.
- run=0: cnt holds, ce_out <= 0, sq_out holds, epoch <= 0.
- resync=1 (priority over counting, regardless of run):
  - Every channel loads cnt <= phase_eff, ce_out <= 0, sq_out <= 0.
  - Counting resumes the next cycle if run=1.
- Configuration writes:
  - cfg_wr with cfg_ch >= NUM_CH: ignored.
  - Otherwise the write goes to the shadow for cfg_ch and sets cfg_pending[cfg_ch].
  - Shadow transfers to the active registers (clearing pending) at the first of:
    - the channel's terminal-count cycle;
    - any cycle with run=0;
    - a resync cycle. In this case the resync loads the new phase and uses the new divisor in the same cycle.
  - cfg_wr and resync in the same cycle: the written values apply immediately for that channel.
  - A second write before transfer overwrites the shadow (last write wins).
  - Transfer at terminal count is glitch-free: the current period completes with the old divisor.
- Epoch:
  - epoch <= 1 when every channel is at terminal count in the same cycle with run=1 and resync=0.
  - epoch_cnt increments in that same cycle, wrapping from 2^EPOCH_W-1 to 0.
  - epoch therefore coincides with the ce_out strobes.
  - Defaults (div 1, 10): epoch every 10 cycles, aligned with ce_out[1].

Decomposition:
- gps_ce_pkg holds:
  - the CFG_CH_W constant (3);
  - the channel-config struct typedef {div, phase};
  - the div_eff/phase_eff clamp functions.
- One sub-module, gps_ce_chan: a single channel with its counter, shadow/active config, ce and sq registers, and a terminal-count flag output.
  - gps_ce_gen instantiates NUM_CH copies, decodes cfg_wr per channel, and ANDs the terminal-count flags to form epoch.

Test Plan:
- Reset defaults, run=1 for 40 cycles:
  - ce_out[0] high every cycle.
  - ce_out[1] pulses at cycles 10, 20, 30, 40 after run.
  - sq_out[1] toggles at each pulse.
  - epoch at the same cycles; epoch_cnt reaches 4.
- Write ch1 div=5 mid-period (cnt=3):
  - cfg_pending[1]=1 until the current 10-cycle period ends.
  - Subsequent ce_out[1] period is 5; no short pulse occurs.
- Write ch1 phase=7, then pulse resync:
  - ce_out[1] = 0 in the resync cycle.
  - First strobe 3 cycles after resync (div 10), then every 10.
- Boundaries:
  - cfg_div=0 behaves as div 1.
  - phase=200 with div=5 clamps to 4, giving the first strobe 1 cycle after resync.
  - cfg_ch=5 with NUM_CH=2 changes nothing; cfg_pending stays 0.
- run low for 6 cycles mid-count: counters hold, ce_out=0, then the phase continues exactly where it stopped.
- Reset and EPOCH_W wrap:
  - Assert sync_rst_in simultaneously with cfg_wr and resync: all outputs 0 and divisors return to DEF_DIV.
  - With EPOCH_W=2, the 5th epoch gives epoch_cnt=1.
